imm_extend_stage: RTL and testbench



---
 rtl/imm_extend_stage.sv | 185 ++++++++++++++++++
 tb/tb_imm_extend_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_stage.sv
// -----------------------------------------------------------------------------
// imm_extend_stage
// Registered immediate-extension stage for the MIPS32 datapath. Widens an
// IN_W-bit immediate to OUT_W bits in one of four runtime modes (zero, sign,
// upper/LUI placement, ones). The result is held behind a valid/ready handshake.
//
// Build option:
//   IMM_EXT_SKID_EN  defined   -> 2-entry skid buffer. in_ready_o comes straight
//                                 from a flop, so out_ready_i never reaches it
//                                 through logic.
//                    undefined -> single output register.
//                                 in_ready_o = !out_valid_o | out_ready_i.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid_i     upstream offers an immediate and a mode
//   in_ready_o     stage accepts this cycle
//   in_imm_i       IN_W-bit immediate
//   in_mode_i      00 zero, 01 sign, 10 upper, 11 ones
//   out_valid_o    out_data_o / out_mode_o hold a result
//   out_ready_i    downstream accepts this cycle
//   out_data_o     OUT_W-bit extended result
//   out_mode_o     mode echoed with the result
// -----------------------------------------------------------------------------
module imm_extend_stage #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_imm_i,
    input  logic [1:0]       in_mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [1:0]       out_mode_o
);

    localparam int unsigned PAD_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_UPPER = 2'b10;
    localparam logic [1:0] MODE_ONES  = 2'b11;

    typedef struct packed {
        logic [1:0]       mode;
        logic [OUT_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t out_q, out_d;
    entry_t new_entry;
    logic   out_valid_q;
    logic   in_fire, out_fire;

    logic [OUT_W-1:0] imm_zext;
    logic [OUT_W-1:0] hi_mask;

    // Bits above the immediate; all-zero when IN_W == OUT_W, so every mode
    // degenerates to a plain pass-through.
    assign imm_zext = OUT_W'(in_imm_i);
    assign hi_mask  = ~OUT_W'({IN_W{1'b1}});

    // Extension of the incoming immediate.
    always_comb begin
        new_entry.mode = in_mode_i;
        new_entry.data = imm_zext;
        case (in_mode_i)
            MODE_ZERO:  new_entry.data = imm_zext;
            MODE_SIGN:  new_entry.data = in_imm_i[IN_W-1] ? (imm_zext | hi_mask) : imm_zext;
            MODE_UPPER: new_entry.data = imm_zext << PAD_W;
            MODE_ONES:  new_entry.data = imm_zext | hi_mask;
            default:    new_entry.data = imm_zext;
        endcase
    end

    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_q.data;
    assign out_mode_o  = out_q.mode;

`ifdef IMM_EXT_SKID_EN

    entry_t skid_q, skid_d;
    logic   in_ready_q;

    assign in_ready_o = in_ready_q;

    // State register plus the datapath and handshake flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= (state_d != ST_EMPTY);
            in_ready_q  <= (state_d != ST_TWO);
        end
    end

    // Occupancy next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_ONE;
            ST_ONE: begin
                if (in_fire && !out_fire)      state_d = ST_TWO;
                else if (out_fire && !in_fire) state_d = ST_EMPTY;
            end
            ST_TWO:   if (out_fire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Entry movement: new results fill the output register when it frees up,
    // otherwise park in the skid register; the skid drains into the output.
    always_comb begin
        out_d  = out_q;
        skid_d = skid_q;
        case (state_q)
            ST_EMPTY: if (in_fire) out_d = new_entry;
            ST_ONE: begin
                if (in_fire && out_fire) out_d  = new_entry;
                else if (in_fire)        skid_d = new_entry;
            end
            ST_TWO:   if (out_fire) out_d = skid_q;
            default: begin
                out_d  = out_q;
                skid_d = skid_q;
            end
        endcase
    end

`else

    // A held result that leaves this cycle frees the register for a new one.
    assign in_ready_o = !out_valid_q | out_ready_i;

    // State register plus the datapath and valid flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    // Occupancy next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_fire) state_d = ST_ONE;
            ST_ONE:   if (out_fire && !in_fire) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // Any accepted input lands in the output register.
    always_comb begin
        out_d = out_q;
        if (in_fire) out_d = new_entry;
    end

`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
`timescale 1ns/1ps
module tb_imm_extend_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 16 -> 32 instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode, out_mode;
    logic [31:0] out_data;

    // 16 -> 16 instance
    logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
    logic [15:0] p_in_imm, p_out_data;
    logic [1:0]  p_in_mode, p_out_mode;

    imm_extend_stage #(.IN_W(16), .OUT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_imm_i(in_imm), .in_mode_i(in_mode),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_data_o(out_data), .out_mode_o(out_mode)
    );

    imm_extend_stage #(.IN_W(16), .OUT_W(16)) dut_eq (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(p_in_valid), .in_ready_o(p_in_ready),
        .in_imm_i(p_in_imm), .in_mode_i(p_in_mode),
        .out_valid_o(p_out_valid), .out_ready_i(p_out_ready),
        .out_data_o(p_out_data), .out_mode_o(p_out_mode)
    );

`ifdef IMM_EXT_SKID_EN
    localparam int STALL_ACCEPTS = 2;
`else
    localparam int STALL_ACCEPTS = 1;
`endif

    localparam logic [31:0] MODES_EXP [6] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_0000,
                                              32'hFFFF_8001, 32'h0000_1234, 32'hFFFF_1234};

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    always @(posedge clk) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  mode;
        int          acc_cyc;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] mode);
        case (mode)
            2'b00:   return {16'h0000, imm};
            2'b01:   return {{16{imm[15]}}, imm};
            2'b10:   return {imm, 16'h0000};
            default: return {16'hFFFF, imm};
        endcase
    endfunction

    // One clock: drive at negedge, observe handshakes #1 later, return at posedge.
    task automatic drive_cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                               input logic rdy, output logic acc, output logic fired,
                               output logic [31:0] d, output logic [1:0] m, output int cyc);
        @(negedge clk);
        in_valid  = v;
        in_imm    = imm;
        in_mode   = mode;
        out_ready = rdy;
        #1;
        acc   = in_valid & in_ready;
        fired = out_valid & out_ready;
        d     = out_data;
        m     = out_mode;
        cyc   = cycle;
        @(posedge clk);
    endtask

    task automatic test_reset();
        in_valid = 0; in_imm = 0; in_mode = 0; out_ready = 0;
        p_in_valid = 0; p_in_imm = 0; p_in_mode = 0; p_out_ready = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (out_mode !== 2'b00) begin errors++; $display("FAIL reset_out_mode got %b want 00", out_mode); end
        checks++; if (p_out_valid !== 1'b0) begin errors++; $display("FAIL reset_eq_out_valid got %b want 0", p_out_valid); end
        rst_n = 1;
    endtask

    task automatic test_modes();
        logic [15:0] imms [6] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'h1234, 16'h1234};
        logic [1:0]  mds  [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11};
        logic acc, fired; logic [31:0] d; logic [1:0] m; int cyc; int outs = 0;
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            drive_cycle(k < 6, imms[k % 6], mds[k % 6], 1'b1, acc, fired, d, m, cyc);
            if (k < 6) begin
                checks++;
                if (acc !== 1'b1) begin errors++; $display("FAIL modes_accept idx %0d got %b want 1", k, acc); end
            end
            if (acc) sb.push_back('{MODES_EXP[k], mds[k], cyc});
            if (fired) begin
                outs++;
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL modes_spurious data %h want none", d);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (d !== e.data || m !== e.mode) begin
                        errors++; $display("FAIL modes_data got %h/%b want %h/%b", d, m, e.data, e.mode);
                    end
                    checks++;
                    if (cyc !== e.acc_cyc + 1) begin
                        errors++; $display("FAIL modes_latency got %0d want %0d", cyc - e.acc_cyc, 1);
                    end
                end
            end
        end
        checks++; if (outs != 6) begin errors++; $display("FAIL modes_count got %0d want 6", outs); end
    endtask

    task automatic test_backpressure();
        logic [15:0] imms [3] = '{16'h00A1, 16'hF0F0, 16'h1357};
        logic [1:0]  mds  [3] = '{2'b00, 2'b01, 2'b10};
        logic acc, fired; logic [31:0] d; logic [1:0] m; int cyc;
        int idx = 0; int outs = 0; int budget = 0;
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            drive_cycle(idx < 3, imms[idx % 3], mds[idx % 3], 1'b0, acc, fired, d, m, cyc);
            if (acc) begin sb.push_back('{model(imms[idx], mds[idx]), mds[idx], cyc}); idx++; end
        end
        #1;
        checks++; if (idx != STALL_ACCEPTS) begin errors++; $display("FAIL bp_accepted got %0d want %0d", idx, STALL_ACCEPTS); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", out_valid); end
        checks++;
        if (out_data !== 32'h0000_00A1 || out_mode !== 2'b00) begin
            errors++; $display("FAIL bp_hold got %h/%b want 000000a1/00", out_data, out_mode);
        end
        while ((idx < 3 || sb.size() != 0) && budget < 20) begin
            budget++;
            drive_cycle(idx < 3, imms[idx % 3], mds[idx % 3], 1'b1, acc, fired, d, m, cyc);
            if (acc) begin sb.push_back('{model(imms[idx], mds[idx]), mds[idx], cyc}); idx++; end
            if (fired) begin
                outs++;
                e = sb.pop_front();
                checks++;
                if (d !== e.data || m !== e.mode) begin
                    errors++; $display("FAIL bp_order got %h/%b want %h/%b", d, m, e.data, e.mode);
                end
            end
        end
        checks++; if (outs != 3) begin errors++; $display("FAIL bp_drained got %0d want 3", outs); end
    endtask

    task automatic test_back_to_back();
        logic acc, fired; logic [31:0] d; logic [1:0] m; int cyc; int outs = 0;
        logic [15:0] imm; logic [1:0] md;
        exp_t e;
        for (int k = 0; k < 9; k++) begin
            imm = 16'($urandom); md = 2'($urandom);
            drive_cycle(k < 8, imm, md, 1'b1, acc, fired, d, m, cyc);
            if (k < 8) begin
                checks++;
                if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept idx %0d got %b want 1", k, acc); end
            end
            if (k >= 1) begin
                checks++;
                if (fired !== 1'b1) begin errors++; $display("FAIL b2b_bubble idx %0d got %b want 1", k, fired); end
            end
            if (acc) sb.push_back('{model(imm, md), md, cyc});
            if (fired && sb.size() != 0) begin
                outs++;
                e = sb.pop_front();
                checks++;
                if (d !== e.data || m !== e.mode || cyc !== e.acc_cyc + 1) begin
                    errors++; $display("FAIL b2b_data got %h/%b lat %0d want %h/%b lat 1",
                                       d, m, cyc - e.acc_cyc, e.data, e.mode);
                end
            end
        end
        checks++; if (outs != 8) begin errors++; $display("FAIL b2b_count got %0d want 8", outs); end
    endtask

    task automatic test_reset_mid();
        logic acc, fired; logic [31:0] d; logic [1:0] m; int cyc; int outs = 0;
        exp_t e;
        drive_cycle(1'b1, 16'h5555, 2'b01, 1'b0, acc, fired, d, m, cyc);
        drive_cycle(1'b1, 16'hAAAA, 2'b10, 1'b0, acc, fired, d, m, cyc);
        @(negedge clk);
        in_valid = 0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full got %b want 0", in_ready); end
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rstmid_out_data got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        drive_cycle(1'b1, 16'h0007, 2'b00, 1'b1, acc, fired, d, m, cyc);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rstmid_first_accept got %b want 1", acc); end
        if (acc) sb.push_back('{32'h0000_0007, 2'b00, cyc});
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b0, 16'hFFFF, 2'b11, 1'b1, acc, fired, d, m, cyc);
            if (fired) begin
                outs++;
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL rstmid_stale data %h want none", d);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (d !== e.data || m !== e.mode) begin
                        errors++; $display("FAIL rstmid_data got %h/%b want %h/%b", d, m, e.data, e.mode);
                    end
                end
            end
        end
        checks++; if (outs != 1) begin errors++; $display("FAIL rstmid_count got %0d want 1", outs); end
    endtask

    task automatic test_random();
        int sent = 0; int outs = 0; int budget = 0;
        logic acc, fired; logic ir0, ir1;
        logic [15:0] imm; logic [1:0] md;
        exp_t e;
        while (outs < 1000 && budget < 20000) begin
            budget++;
            @(negedge clk);
            imm = 16'($urandom); md = 2'($urandom);
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            in_imm    = imm;
            in_mode   = md;
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
`ifdef IMM_EXT_SKID_EN
            ir0 = in_ready;
            out_ready = ~out_ready;
            #1;
            ir1 = in_ready;
            out_ready = ~out_ready;
            #1;
            checks++;
            if (ir0 !== ir1) begin errors++; $display("FAIL rand_ready_path got %b want %b", ir1, ir0); end
`else
            ir0 = 1'b0; ir1 = 1'b0;
`endif
            acc   = in_valid & in_ready;
            fired = out_valid & out_ready;
            if (acc) begin sb.push_back('{model(imm, md), md, cycle}); sent++; end
            if (fired) begin
                outs++;
                if (sb.size() == 0) begin
                    checks++; errors++; $display("FAIL rand_spurious data %h want none", out_data);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (out_data !== e.data || out_mode !== e.mode) begin
                        errors++; $display("FAIL rand_data #%0d got %h/%b want %h/%b",
                                           outs, out_data, out_mode, e.data, e.mode);
                    end
                end
            end
            @(posedge clk);
        end
        checks++; if (outs != 1000) begin errors++; $display("FAIL rand_timeout got %0d want 1000", outs); end
        @(negedge clk);
        in_valid = 0;
    endtask

    task automatic test_passthrough();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            p_in_valid = 1; p_in_imm = 16'hABCD; p_in_mode = 2'(k); p_out_ready = 1;
            @(posedge clk);
            #1;
            checks++;
            if (p_out_valid !== 1'b1 || p_out_data !== 16'hABCD || p_out_mode !== 2'(k)) begin
                errors++; $display("FAIL eq_pass mode %0d got %b/%h/%b want 1/abcd/%0d",
                                   k, p_out_valid, p_out_data, p_out_mode, k);
            end
        end
        @(negedge clk);
        p_in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
